// File: rtl/demux_stream_dispatcher_pkg.sv
// Shared definitions for the stream dispatcher: mode encodings and the
// holding-register state type.
package demux_stream_dispatcher_pkg;

  localparam logic MODE_RR    = 1'b0;
  localparam logic MODE_FIXED = 1'b1;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } state_t;

endpackage

// File: rtl/demux_stream_dispatcher_next_sel.sv
// Round-robin search: returns the first enabled destination at or after
// ptr, wrapping modulo N. found is low when no destination is enabled.
module rr_next_sel #(
  parameter int N  = 4,
  parameter int SW = $clog2(N)
) (
  input  logic [SW-1:0] ptr,
  input  logic [N-1:0]  en_mask,
  output logic [SW-1:0] idx,
  output logic          found
);

  // Scan from the farthest offset back to ptr so the nearest hit wins.
  always_comb begin
    // NOTE: every output gets a default before any conditional assignment,
    // so no path leaves a value unassigned and no latch is inferred.
    idx   = '0;
    found = |en_mask;
    for (int k = N - 1; k >= 0; k--) begin
      if (en_mask[(int'(ptr) + k) % N]) begin
        idx = SW'((int'(ptr) + k) % N);
      end
    end
  end

endmodule

// File: rtl/demux_stream_dispatcher.sv
// 1-to-N dispatcher for a valid/ready byte stream. One holding register
// carries each accepted beat to a single destination chosen either
// round-robin over enabled outputs or by a fixed select.
module demux_stream_dispatcher
  import demux_stream_dispatcher_pkg::*;
#(
  parameter int N = 4,
  parameter int W = 8,
  localparam int SW = $clog2(N)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [W-1:0]  in_data,
  input  logic          mode,
  input  logic [SW-1:0] fix_sel,
  input  logic [N-1:0]  en_mask,
  output logic [N-1:0]  out_valid,
  input  logic [N-1:0]  out_ready,
  output logic [W-1:0]  out_data,
  output logic [SW-1:0] grant,
  output logic          busy
);

  state_t        state, state_nxt;
  logic [SW-1:0] ptr;
  logic [SW-1:0] rr_idx;
  logic          rr_found;
  logic [SW-1:0] target;
  logic          target_ok;
  logic          drain;
  logic          accept;

  rr_next_sel #(.N(N), .SW(SW)) u_next_sel (
    .ptr     (ptr),
    .en_mask (en_mask),
    .idx     (rr_idx),
    .found   (rr_found)
  );

  // Destination for a beat offered this cycle, and whether it may be taken.
  always_comb begin
    target    = rr_idx;
    target_ok = rr_found;
    if (mode == MODE_FIXED) begin
      target    = fix_sel;
      target_ok = (int'(fix_sel) < N) && en_mask[fix_sel];
    end
  end

  // Drain frees the slot in the same cycle, giving one beat per clock.
  assign drain    = (state == ST_FULL) && out_ready[grant];
  assign in_ready = !rst && ((state == ST_EMPTY) || drain) && target_ok;
  assign accept   = in_valid && in_ready;
  assign busy     = (state == ST_FULL);

  // Next state of the holding register and one-hot output decode.
  always_comb begin
    state_nxt = state;
    out_valid = '0;
    case (state)
      ST_EMPTY: if (accept) state_nxt = ST_FULL;
      ST_FULL: begin
        out_valid[grant] = 1'b1;
        if (accept)     state_nxt = ST_FULL;
        else if (drain) state_nxt = ST_EMPTY;
      end
      default: state_nxt = ST_EMPTY;
    endcase
  end

  // State, held beat, its grant and the round-robin pointer.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: the data register is reset too, because out_data is visible
    // to every consumer and must read as zero straight out of reset.
    if (rst) begin
      state    <= ST_EMPTY;
      out_data <= '0;
      grant    <= '0;
      ptr      <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the
      // pre-edge values regardless of statement order.
      state <= state_nxt;
      if (accept) begin
        out_data <= in_data;
        grant    <= target;
        if (mode == MODE_RR) begin
          ptr <= (target == SW'(N - 1)) ? '0 : target + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_demux_stream_dispatcher.sv
// Directed bench with a scoreboard: stimulus pushes the expected
// destination/data of each accepted beat, a monitor pops on every
// output handshake and compares.
module tb_demux_stream_dispatcher;

  localparam int N  = 4;
  localparam int W  = 8;
  localparam int SW = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  in_data;
  logic          mode;
  logic [SW-1:0] fix_sel;
  logic [N-1:0]  en_mask;
  logic [N-1:0]  out_valid;
  logic [N-1:0]  out_ready;
  logic [W-1:0]  out_data;
  logic [SW-1:0] grant;
  logic          busy;

  typedef struct packed {
    logic [SW-1:0] dest;
    logic [W-1:0]  data;
  } beat_t;

  beat_t sb[$];
  int    n_checks = 0;
  int    n_pass   = 0;

  demux_stream_dispatcher #(.N(N), .W(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .mode      (mode),
    .fix_sel   (fix_sel),
    .en_mask   (en_mask),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .grant     (grant),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // Monitor: every output handshake must match the oldest expected beat.
  always @(negedge clk) begin
    if (!rst && out_valid != '0 && (out_valid & out_ready) != '0) begin
      if (sb.size() == 0) begin
        check("unexpected_beat", {24'd0, out_data}, 32'hFFFF_FFFF);
      end else begin
        beat_t b;
        b = sb.pop_front();
        check("out_valid_onehot", {28'd0, out_valid}, 32'(1) << b.dest);
        check("grant", {30'd0, grant}, {30'd0, b.dest});
        check("out_data", {24'd0, out_data}, {24'd0, b.data});
      end
    end
  end

  // Offer one beat; push its expectation when the DUT accepts it.
  task automatic send(input logic [W-1:0] d, input logic [SW-1:0] dest, output int waited);
    bit done;
    done     = 0;
    waited   = 0;
    in_valid = 1'b1;
    in_data  = d;
    for (int c = 0; c < 20 && !done; c++) begin
      @(negedge clk);
      if (in_ready) begin
        sb.push_back('{dest: dest, data: d});
        done = 1;
      end else begin
        waited++;
      end
      @(posedge clk);
      #1;
    end
    if (!done) check("send_timeout", 32'd0, 32'd1);
  endtask

  task automatic idle(input int cycles);
    in_valid = 1'b0;
    repeat (cycles) @(posedge clk);
    #1;
  endtask

  initial begin
    int w;
    rst = 1'b1; in_valid = 1'b0; in_data = '0; mode = 1'b0;
    fix_sel = '0; en_mask = 4'b1111; out_ready = 4'b1111;
    #2;
    check("por_busy", {31'd0, busy}, 32'd0);
    check("por_in_ready", {31'd0, in_ready}, 32'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // Test 1: asynchronous reset while a beat is held.
    mode = 1'b1; fix_sel = 2'd0; out_ready = 4'b0000;
    send(8'hA5, 2'd0, w);
    idle(1);
    check("t1_full_busy", {31'd0, busy}, 32'd1);
    check("t1_full_data", {24'd0, out_data}, 32'hA5);
    #2 rst = 1'b1;
    #1;
    check("t1_rst_busy", {31'd0, busy}, 32'd0);
    check("t1_rst_out_valid", {28'd0, out_valid}, 32'd0);
    check("t1_rst_out_data", {24'd0, out_data}, 32'd0);
    check("t1_rst_grant", {30'd0, grant}, 32'd0);
    check("t1_rst_in_ready", {31'd0, in_ready}, 32'd0);
    sb.delete();
    @(posedge clk);
    #1 rst = 1'b0;
    out_ready = 4'b1111;

    // Test 2: round-robin streaming, full throughput.
    mode = 1'b0; en_mask = 4'b1111;
    for (int i = 0; i < 8; i++) begin
      send(8'h10 + 8'(i), 2'(i % 4), w);
      check("t2_no_stall", 32'(w), 32'd0);
    end
    idle(3);

    // Test 3: disabled destinations skipped.
    en_mask = 4'b1010;
    send(8'h20, 2'd1, w);
    send(8'h21, 2'd3, w);
    send(8'h22, 2'd1, w);
    idle(3);

    // Test 4: backpressure in fixed mode, then drain+accept in one cycle.
    mode = 1'b1; fix_sel = 2'd2; en_mask = 4'b1111; out_ready = 4'b1011;
    send(8'h40, 2'd2, w);
    in_data = 8'h41;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      check("t4_out_valid", {28'd0, out_valid}, 32'b0100);
      check("t4_hold_data", {24'd0, out_data}, 32'h40);
      check("t4_in_ready", {31'd0, in_ready}, 32'd0);
      @(posedge clk);
      #1;
    end
    out_ready = 4'b1111;
    send(8'h41, 2'd2, w);
    check("t4_same_cycle", 32'(w), 32'd0);
    check("t4_new_data", {24'd0, out_data}, 32'h41);
    check("t4_still_busy", {31'd0, busy}, 32'd1);
    idle(3);

    // Test 5: no valid target, then a target appears.
    fix_sel = 2'd1; en_mask = 4'b1101; in_valid = 1'b1; in_data = 8'h50;
    @(negedge clk);
    check("t5_fixed_disabled", {31'd0, in_ready}, 32'd0);
    mode = 1'b0; en_mask = 4'b0000;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      check("t5_no_target", {31'd0, in_ready}, 32'd0);
    end
    @(posedge clk);
    #1 en_mask = 4'b0001;
    send(8'h50, 2'd0, w);
    check("t5_accept_now", 32'(w), 32'd0);
    idle(3);

    // Test 6: mask drop while held keeps grant; later RR skips 3.
    en_mask = 4'b1000; out_ready = 4'b0111;
    send(8'h60, 2'd3, w);
    in_valid = 1'b0;
    en_mask = 4'b0111;
    @(negedge clk);
    check("t6_held_grant", {30'd0, grant}, 32'd3);
    check("t6_held_valid", {28'd0, out_valid}, 32'b1000);
    @(posedge clk);
    #1 out_ready = 4'b1111;
    idle(2);
    send(8'h61, 2'd0, w);
    send(8'h62, 2'd1, w);
    send(8'h63, 2'd2, w);
    send(8'h64, 2'd0, w);
    idle(4);

    check("sb_empty", 32'(sb.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
